// File: rtl/tbus_pkg.sv
// -----------------------------------------------------------------------------
// tbus_pkg
// Shared definitions for the tri-state register bus read controller:
//   - state_t       : controller FSM states (IDLE / SELECT / RESP)
//   - CS_IDLE       : all-ones chip-select pattern (every register released)
//   - DEFAULT_*     : default bus width, register count and address width
//   - cnt_width()   : width of the settle counter for a given settle length
// Optional feature macro used by the importing files: TBUS_BURST_EN
// -----------------------------------------------------------------------------
package tbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEFAULT_NR_OF_BITS = 32;
    localparam int DEFAULT_NR_OF_REGS = 8;
    localparam int DEFAULT_ADDR_BITS  = 3;

    // Wide enough for any realistic bank; users slice the low NrOfRegs bits.
    localparam int                  MAX_REGS = 256;
    localparam logic [MAX_REGS-1:0] CS_IDLE  = '1;

    // The counter must be able to hold the value SettleCycles itself.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/tbus_read_controller_if.sv
// -----------------------------------------------------------------------------
// tbus_read_controller_if
// Request/response channels between a datapath reader and the tri-state bus
// read controller.
//   req_valid/req_ready/req_addr/req_len : read request (req_len used only when
//                                          TBUS_BURST_EN is defined)
//   rsp_valid/rsp_ready/rsp_data/rsp_addr/rsp_err : read response
// Modports: master = requester (datapath), slave = controller.
// -----------------------------------------------------------------------------
interface tbus_read_controller_if
    import tbus_pkg::*;
#(
    parameter int NrOfBits = DEFAULT_NR_OF_BITS,
    parameter int AddrBits = DEFAULT_ADDR_BITS
);
    logic                req_valid;
    logic                req_ready;
    logic [AddrBits-1:0] req_addr;
    logic [AddrBits-1:0] req_len;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NrOfBits-1:0] rsp_data;
    logic [AddrBits-1:0] rsp_addr;
    logic                rsp_err;

    modport master (
        output req_valid, req_addr, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/tbus_cs_decode.sv
// -----------------------------------------------------------------------------
// tbus_cs_decode
// Registered one-hot-low chip-select decoder for the tri-state register bank.
// Ports:
//   Clock, Reset (async, active-high, forces cs to all ones), Tick (clock enable)
//   load       : select register addr on this Tick edge (if addr is in range)
//   release_cs : drive every cs bit high on this Tick edge (wins over load)
//   addr       : register index to select
//   cs         : active-low chip selects, at most one bit low at a time
// -----------------------------------------------------------------------------
module tbus_cs_decode
    import tbus_pkg::*;
#(
    parameter int NrOfRegs = DEFAULT_NR_OF_REGS,
    parameter int AddrBits = DEFAULT_ADDR_BITS
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                load,
    input  logic                release_cs,
    input  logic [AddrBits-1:0] addr,
    output logic [NrOfRegs-1:0] cs
);
    localparam logic [AddrBits:0] NR_REGS = (AddrBits + 1)'(NrOfRegs);

    // Out-of-range indices select nothing, leaving the bus fully released.
    logic in_range;
    assign in_range = ({1'b0, addr} < NR_REGS);

    genvar gi;
    generate
        for (gi = 0; gi < NrOfRegs; gi++) begin : g_cs
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    cs[gi] <= CS_IDLE[gi];
                end else if (Tick) begin
                    if (release_cs) begin
                        cs[gi] <= 1'b1;
                    end else if (load) begin
                        cs[gi] <= !(in_range && (addr == AddrBits'(gi)));
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tbus_read_controller.sv
// -----------------------------------------------------------------------------
// tbus_read_controller
// Reader side of the shared tri-state register bus: selects one register via
// its active-low cs line, holds it for SettleCycles+1 Tick periods, samples the
// bus and returns the word on a valid/ready response channel.
// Ports:
//   Clock, Reset (async, active-high), Tick (clock enable for all state)
//   bus_if : tbus_read_controller_if.slave (request/response channels)
//   cs     : active-low chip selects to the register bank (registered)
//   bus_in : resolved shared bus value
// Configuration macro: TBUS_BURST_EN - when defined, a request reads
//   req_len+1 consecutive registers (index wraps NrOfRegs-1 -> 0).
// -----------------------------------------------------------------------------
module tbus_read_controller
    import tbus_pkg::*;
#(
    parameter int NrOfBits     = DEFAULT_NR_OF_BITS,
    parameter int NrOfRegs     = DEFAULT_NR_OF_REGS,
    parameter int AddrBits     = DEFAULT_ADDR_BITS,
    parameter int SettleCycles = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Tick,
    tbus_read_controller_if.slave bus_if,
    output logic [NrOfRegs-1:0]   cs,
    input  logic [NrOfBits-1:0]   bus_in
);
    localparam int                  CntBits     = cnt_width(SettleCycles);
    localparam logic [CntBits-1:0]  SETTLE_LAST = CntBits'(SettleCycles);
    localparam logic [AddrBits:0]   NR_REGS     = (AddrBits + 1)'(NrOfRegs);

    state_t              state_reg;
    logic [AddrBits-1:0] addr_reg;
    logic                err_reg;
    logic [CntBits-1:0]  cnt_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [NrOfBits-1:0] rsp_data_reg;
    logic [AddrBits-1:0] rsp_addr_reg;
    logic                rsp_err_reg;

    logic                cs_load;
    logic                cs_release;
    logic [AddrBits-1:0] cs_addr;
    logic                req_err;

    assign req_err = ({1'b0, bus_if.req_addr} >= NR_REGS);

`ifdef TBUS_BURST_EN
    localparam logic [AddrBits-1:0] LAST_ADDR = AddrBits'(NrOfRegs - 1);

    logic [AddrBits-1:0] len_reg;
    logic [AddrBits-1:0] next_addr;
    logic                next_err;
    logic                next_word;

    assign next_addr = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
    assign next_err  = ({1'b0, next_addr} >= NR_REGS);
    assign next_word = Tick && (state_reg == RESP) && bus_if.rsp_ready && (len_reg != '0);
    assign cs_addr   = (state_reg == IDLE) ? bus_if.req_addr : next_addr;
`else
    logic next_word;
    logic unused_req_len;

    assign next_word      = 1'b0;
    assign cs_addr        = bus_if.req_addr;
    assign unused_req_len = ^bus_if.req_len;
`endif

    // Decoder controls mirror the FSM transitions below so cs changes on the
    // same Tick edge as the state.
    assign cs_load    = (Tick && (state_reg == IDLE) && bus_if.req_valid) || next_word;
    assign cs_release = Tick && (state_reg == SELECT) && (cnt_reg == SETTLE_LAST);

    tbus_cs_decode #(
        .NrOfRegs (NrOfRegs),
        .AddrBits (AddrBits)
    ) u_cs_decode (
        .Clock      (Clock),
        .Reset      (Reset),
        .Tick       (Tick),
        .load       (cs_load),
        .release_cs (cs_release),
        .addr       (cs_addr),
        .cs         (cs)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_addr_reg  <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef TBUS_BURST_EN
            len_reg       <= '0;
`endif
        end else if (Tick) begin
            case (state_reg)
                IDLE: begin
                    if (bus_if.req_valid) begin
                        addr_reg      <= bus_if.req_addr;
                        err_reg       <= req_err;
                        cnt_reg       <= '0;
                        req_ready_reg <= 1'b0;
                        state_reg     <= SELECT;
`ifdef TBUS_BURST_EN
                        len_reg       <= bus_if.req_len;
`endif
                    end
                end
                SELECT: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        rsp_data_reg  <= err_reg ? '1 : bus_in;
                        rsp_addr_reg  <= addr_reg;
                        rsp_err_reg   <= err_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (bus_if.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
`ifdef TBUS_BURST_EN
                        if (len_reg != '0) begin
                            addr_reg  <= next_addr;
                            err_reg   <= next_err;
                            len_reg   <= len_reg - 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= SELECT;
                        end else begin
                            req_ready_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
`else
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus_if.req_ready = req_ready_reg;
    assign bus_if.rsp_valid = rsp_valid_reg;
    assign bus_if.rsp_data  = rsp_data_reg;
    assign bus_if.rsp_addr  = rsp_addr_reg;
    assign bus_if.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_tbus_read_controller.sv
// -----------------------------------------------------------------------------
// tb_tbus_read_controller
// Directed bench for tbus_read_controller. Instance A: 8 registers on the bus,
// instance B: 6 registers (3-bit index, so indices 6 and 7 are out of range).
// Register i holds 32'h1000_0000+i, except register 3 which holds 32'hDEADBEEF.
// Inputs change and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tbus_read_controller;
    localparam int NB = 32;
    localparam int AB = 3;

    logic Clock = 1'b0;
    logic Reset;
    logic Tick;
    always #5 Clock = ~Clock;

    tbus_read_controller_if #(.NrOfBits(NB), .AddrBits(AB)) ifa ();
    tbus_read_controller_if #(.NrOfBits(NB), .AddrBits(AB)) ifb ();

    logic [7:0]    cs_a;
    logic [5:0]    cs_b;
    logic [NB-1:0] bus_a;
    logic [NB-1:0] bus_b;

    function automatic logic [NB-1:0] reg_val(input int i);
        return (i == 3) ? 32'hDEADBEEF : 32'h1000_0000 + NB'(i);
    endfunction

    // Bank model: a selected register drives the bus; otherwise a float pattern.
    always_comb begin
        bus_a = 32'hA5A5_A5A5;
        for (int i = 0; i < 8; i++) if (!cs_a[i]) bus_a = reg_val(i);
    end
    always_comb begin
        bus_b = 32'hA5A5_A5A5;
        for (int i = 0; i < 6; i++) if (!cs_b[i]) bus_b = reg_val(i);
    end

    tbus_read_controller #(.NrOfBits(NB), .NrOfRegs(8), .AddrBits(AB), .SettleCycles(1)) dut_a (
        .Clock  (Clock),
        .Reset  (Reset),
        .Tick   (Tick),
        .bus_if (ifa),
        .cs     (cs_a),
        .bus_in (bus_a)
    );

    tbus_read_controller #(.NrOfBits(NB), .NrOfRegs(6), .AddrBits(AB), .SettleCycles(1)) dut_b (
        .Clock  (Clock),
        .Reset  (Reset),
        .Tick   (Tick),
        .bus_if (ifb),
        .cs     (cs_b),
        .bus_in (bus_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; every step also confirms at most one cs bit is low.
    task automatic step();
        @(negedge Clock);
        chk("cs_a_single_low", NB'($countones(~cs_a) <= 1), 1);
        chk("cs_b_single_low", NB'($countones(~cs_b) <= 1), 1);
    endtask

    initial begin
        Reset = 1'b1;
        Tick  = 1'b0;
        ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.req_len = '0; ifa.rsp_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_len = '0; ifb.rsp_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_cs_a",      NB'(cs_a),          NB'(8'hFF));
        chk("rst_cs_b",      NB'(cs_b),          NB'(6'h3F));
        chk("rst_req_ready", NB'(ifa.req_ready), 1);
        chk("rst_rsp_valid", NB'(ifa.rsp_valid), 0);
        chk("rst_rsp_data",  ifa.rsp_data,       0);
        chk("rst_rsp_addr",  NB'(ifa.rsp_addr),  0);
        chk("rst_rsp_err",   NB'(ifa.rsp_err),   0);
        Reset = 1'b0;

        // Basic read of register 3, Tick always high
        Tick = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_addr = 3'd3;
        step();
        ifa.req_valid = 1'b0;
        chk("rd3_cs_1",        NB'(cs_a),          NB'(8'hF7));
        chk("rd3_req_ready",   NB'(ifa.req_ready), 0);
        chk("rd3_valid_early", NB'(ifa.rsp_valid), 0);
        step();
        chk("rd3_cs_2",        NB'(cs_a),          NB'(8'hF7));
        chk("rd3_valid_early", NB'(ifa.rsp_valid), 0);
        step();
        chk("rd3_valid",  NB'(ifa.rsp_valid), 1);
        chk("rd3_data",   ifa.rsp_data,       32'hDEADBEEF);
        chk("rd3_addr",   NB'(ifa.rsp_addr),  3);
        chk("rd3_err",    NB'(ifa.rsp_err),   0);
        chk("rd3_cs_rel", NB'(cs_a),          NB'(8'hFF));
        $display("read A addr=%0d data=%h err=%0b", ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err);

        // Back-pressure: response held for 5 clocks
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid",     NB'(ifa.rsp_valid), 1);
            chk("hold_data",      ifa.rsp_data,       32'hDEADBEEF);
            chk("hold_cs",        NB'(cs_a),          NB'(8'hFF));
            chk("hold_req_ready", NB'(ifa.req_ready), 0);
        end
        ifa.rsp_ready = 1'b1;
        step();
        ifa.rsp_ready = 1'b0;
        chk("take_valid",     NB'(ifa.rsp_valid), 0);
        chk("take_req_ready", NB'(ifa.req_ready), 1);

        // Tick every 3rd clock: accept at k=2, count at k=5, sample at k=8
        Tick = 1'b0;
        ifa.req_valid = 1'b1; ifa.req_addr = 3'd5;
        for (int k = 0; k < 9; k++) begin
            Tick = (k % 3 == 2);
            step();
            if (k == 2) ifa.req_valid = 1'b0;
            chk("tick_cs",        NB'(cs_a),          (k >= 2 && k < 8) ? NB'(8'hDF) : NB'(8'hFF));
            chk("tick_rsp_valid", NB'(ifa.rsp_valid), (k >= 8) ? 1 : 0);
            chk("tick_req_ready", NB'(ifa.req_ready), (k < 2) ? 1 : 0);
        end
        chk("tick_data", ifa.rsp_data, 32'h1000_0005);
        $display("read A addr=%0d data=%h err=%0b", ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err);
        Tick = 1'b0;
        ifa.rsp_ready = 1'b1;
        step();
        chk("tick0_no_take", NB'(ifa.rsp_valid), 1);
        Tick = 1'b1;
        step();
        ifa.rsp_ready = 1'b0;
        chk("tick1_take",       NB'(ifa.rsp_valid), 0);
        chk("tick1_req_ready",  NB'(ifa.req_ready), 1);

        // Reset in the middle of a SELECT window on register 2
        ifa.req_valid = 1'b1; ifa.req_addr = 3'd2;
        step();
        ifa.req_valid = 1'b0;
        chk("mid_cs_sel", NB'(cs_a), NB'(8'hFB));
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_cs",        NB'(cs_a),          NB'(8'hFF));
        chk("mid_rst_req_ready", NB'(ifa.req_ready), 1);
        chk("mid_rst_rsp_valid", NB'(ifa.rsp_valid), 0);
        step();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_no_rsp", NB'(ifa.rsp_valid), 0);
            chk("mid_cs_idle", NB'(cs_a), NB'(8'hFF));
        end

        // Out-of-range index on the 6-register instance
        ifb.req_valid = 1'b1; ifb.req_addr = 3'd7;
        step();
        ifb.req_valid = 1'b0;
        chk("oor_cs_1", NB'(cs_b), NB'(6'h3F));
        step();
        chk("oor_cs_2", NB'(cs_b), NB'(6'h3F));
        chk("oor_valid_early", NB'(ifb.rsp_valid), 0);
        step();
        chk("oor_valid", NB'(ifb.rsp_valid), 1);
        chk("oor_err",   NB'(ifb.rsp_err),   1);
        chk("oor_data",  ifb.rsp_data,       32'hFFFF_FFFF);
        chk("oor_addr",  NB'(ifb.rsp_addr),  7);
        chk("oor_cs_3",  NB'(cs_b),          NB'(6'h3F));
        $display("read B addr=%0d data=%h err=%0b", ifb.rsp_addr, ifb.rsp_data, ifb.rsp_err);
        ifb.rsp_ready = 1'b1;
        step();
        ifb.rsp_ready = 1'b0;
        chk("oor_take", NB'(ifb.rsp_valid), 0);

`ifdef TBUS_BURST_EN
        // Burst of 3 words from register 6, wrapping to 0
        ifa.req_valid = 1'b1; ifa.req_addr = 3'd6; ifa.req_len = 3'd2;
        ifa.rsp_ready = 1'b1;
        step();
        ifa.req_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            int waited;
            int exp_addr;
            exp_addr = (6 + w) % 8;
            waited = 0;
            while (!ifa.rsp_valid && waited < 20) begin
                step();
                waited++;
            end
            chk("burst_timeout", NB'(waited < 20), 1);
            chk("burst_data",    ifa.rsp_data,      reg_val(exp_addr));
            chk("burst_addr",    NB'(ifa.rsp_addr), NB'(exp_addr));
            chk("burst_gap_cs",  NB'(cs_a),         NB'(8'hFF));
            $display("read A addr=%0d data=%h err=%0b", ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err);
            step();
            chk("burst_req_ready", NB'(ifa.req_ready), (w == 2) ? 1 : 0);
            chk("burst_valid_drop", NB'(ifa.rsp_valid), 0);
        end
        ifa.rsp_ready = 1'b0;
        ifa.req_len = '0;
`else
        // Without bursts req_len is ignored: exactly one word comes back
        ifa.req_valid = 1'b1; ifa.req_addr = 3'd6; ifa.req_len = 3'd2;
        ifa.rsp_ready = 1'b1;
        step();
        ifa.req_valid = 1'b0;
        step();
        step();
        chk("single_valid", NB'(ifa.rsp_valid), 1);
        chk("single_data",  ifa.rsp_data,       32'h1000_0006);
        chk("single_addr",  NB'(ifa.rsp_addr),  6);
        $display("read A addr=%0d data=%h err=%0b", ifa.rsp_addr, ifa.rsp_data, ifa.rsp_err);
        step();
        chk("single_req_ready", NB'(ifa.req_ready), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("single_no_more", NB'(ifa.rsp_valid), 0);
            chk("single_cs_idle", NB'(cs_a), NB'(8'hFF));
        end
        ifa.rsp_ready = 1'b0;
        ifa.req_len = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
